// File: rtl/exp3_unidade_controle.sv
//==============================================================================
// Module   : exp3_unidade_controle
// Brief    : Moore control unit sequencing one switch-vs-memory game round.
//            Optional macro TIMEOUT_EN adds a play timeout (state FIM_TIMEOUT).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module exp3_unidade_controle
`ifdef TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CICLOS = 3000
)
`endif
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    estado_t r_estado;
    estado_t w_proximoEstado;
    logic    r_jogadaD;
    logic    w_jogadaPulso;

    assign w_jogadaPulso = jogada & ~r_jogadaD;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= INICIAL;
            r_jogadaD <= 1'b0;
        end else begin
            r_estado  <= w_proximoEstado;
            r_jogadaD <= jogada;
        end
    end

`ifdef TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LIMITE = 16'(TIMEOUT_CICLOS - 1);

    logic [15:0] r_contTimeout;
    logic        w_expirou;

    // Counts only while waiting for a play; any other state restarts the window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_contTimeout <= 16'd0;
        end else if (r_estado == ESPERA) begin
            r_contTimeout <= r_contTimeout + 16'd1;
        end else begin
            r_contTimeout <= 16'd0;
        end
    end

    assign w_expirou = (r_contTimeout == c_TIMEOUT_LIMITE);
`endif

    always_comb begin
        w_proximoEstado = INICIAL;
        case (r_estado)
            INICIAL:     w_proximoEstado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_proximoEstado = ESPERA;
            ESPERA: begin
                w_proximoEstado = ESPERA;
                if (w_jogadaPulso) begin
                    w_proximoEstado = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (w_expirou) begin
                    w_proximoEstado = FIM_TIMEOUT;
`endif
                end
            end
            REGISTRA:    w_proximoEstado = COMPARACAO;
            // A miss outranks the last-address flag.
            COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    w_proximoEstado = FIM_ERROU;
                end else if (fimC) begin
                    w_proximoEstado = FIM_ACERTOU;
                end else begin
                    w_proximoEstado = PROXIMO;
                end
            end
            PROXIMO:     w_proximoEstado = ESPERA;
            FIM_ACERTOU: w_proximoEstado = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   w_proximoEstado = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: w_proximoEstado = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:     w_proximoEstado = INICIAL;
        endcase
    end

    assign zeraC     = (r_estado == PREPARACAO);
    assign zeraR     = (r_estado == PREPARACAO);
    assign registraR = (r_estado == REGISTRA);
    assign contaC    = (r_estado == PROXIMO);
    assign acertou   = (r_estado == FIM_ACERTOU);
    assign errou     = (r_estado == FIM_ERROU);
`ifdef TIMEOUT_EN
    assign timeout   = (r_estado == FIM_TIMEOUT);
    assign pronto    = (r_estado == FIM_ACERTOU) || (r_estado == FIM_ERROU) ||
                       (r_estado == FIM_TIMEOUT);
`else
    assign timeout   = 1'b0;
    assign pronto    = (r_estado == FIM_ACERTOU) || (r_estado == FIM_ERROU);
`endif
    assign db_estado = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_exp3_unidade_controle.sv
//==============================================================================
// Module   : tb_exp3_unidade_controle
// Brief    : Directed scoreboard bench for exp3_unidade_controle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exp3_unidade_controle;

    localparam int unsigned c_TIMEOUT_CICLOS = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    int nVetores = 0;
    int nErros   = 0;
    int nRegistra = 0;
    int nConta    = 0;

    string       qTag[$];
    logic [11:0] qEsperado[$];

`ifdef TIMEOUT_EN
    exp3_unidade_controle #(.TIMEOUT_CICLOS(c_TIMEOUT_CICLOS)) dut (
`else
    exp3_unidade_controle dut (
`endif
        .clock              (clock),
        .reset_n            (reset_n),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (registraR) nRegistra = nRegistra + 1;
        if (contaC)    nConta    = nConta + 1;
    end

    // Expected outputs for a state code: {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}
    function automatic logic [7:0] saidasDe(input logic [3:0] code);
        case (code)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hE:    return 8'b0000_1010;
            4'hF:    return 8'b0000_1001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic empilha(input string tag, input logic [3:0] code);
        qTag.push_back(tag);
        qEsperado.push_back({code, saidasDe(code)});
    endtask

    task automatic confere();
        string       tag;
        logic [11:0] esp;
        logic [11:0] obs;
        tag = qTag.pop_front();
        esp = qEsperado.pop_front();
        obs = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        nVetores++;
        assert (obs === esp) else begin
            nErros++;
            $error("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic confereInt(input string tag, input int obs, input int esp);
        nVetores++;
        assert (obs === esp) else begin
            nErros++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Drive inputs, queue the state expected after the next edge, then check it.
    task automatic passo(input string tag, input logic ini, input logic jog,
                         input logic igu, input logic fim, input logic [3:0] code);
        iniciar            = ini;
        jogada             = jog;
        chavesIgualMemoria = igu;
        fimC               = fim;
        empilha(tag, code);
        @(posedge clock);
        #1;
        confere();
    endtask

    task automatic joga(input string tag, input logic igu, input logic fim,
                        input logic [3:0] fimCode);
        passo({tag, "_reg"}, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4);
        passo({tag, "_cmp"}, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
        passo({tag, "_dec"}, 1'b0, 1'b0, igu,  fim,  fimCode);
        if (fimCode == 4'h6) passo({tag, "_esp"}, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
    endtask

    int baseReg;
    int baseConta;

    initial begin
        reset_n = 1'b0; iniciar = 1'b0; jogada = 1'b0;
        chavesIgualMemoria = 1'b1; fimC = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        empilha("reset", 4'h0);
        confere();
        reset_n = 1'b1;
        passo("ocioso", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

        // Full winning game
        passo("prep1", 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
        passo("espera1", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        passo("espera1b", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        baseReg = nRegistra; baseConta = nConta;
        for (int i = 0; i < 16; i++) begin
            joga($sformatf("g1p%0d", i), 1'b1, (i == 15), (i == 15) ? 4'hA : 4'h6);
        end
        confereInt("g1_registraR", nRegistra - baseReg, 16);
        confereInt("g1_contaC", nConta - baseConta, 15);
        passo("acertouHold", 1'b0, 1'b0, 1'b1, 1'b0, 4'hA);

        // Miss on the third play
        passo("prep2", 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
        passo("espera2", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        baseConta = nConta;
        joga("g2p0", 1'b1, 1'b0, 4'h6);
        joga("g2p1", 1'b1, 1'b0, 4'h6);
        joga("g2p2", 1'b0, 1'b0, 4'hE);
        confereInt("g2_contaC", nConta - baseConta, 2);
        passo("errouHold", 1'b0, 1'b0, 1'b1, 1'b0, 4'hE);
        passo("prep3", 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
        passo("espera3", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);

        // jogada held high for 10 cycles gives one play only
        baseReg = nRegistra;
        passo("held_reg", 1'b0, 1'b1, 1'b1, 1'b0, 4'h4);
        passo("held_cmp", 1'b0, 1'b1, 1'b1, 1'b0, 4'h5);
        passo("held_prox", 1'b0, 1'b1, 1'b1, 1'b0, 4'h6);
        for (int i = 0; i < 7; i++) begin
            passo($sformatf("held_esp%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        end
        passo("held_solta", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        confereInt("held_registraR", nRegistra - baseReg, 1);
        passo("novaBorda", 1'b0, 1'b1, 1'b1, 1'b0, 4'h4);
        passo("novaCmp", 1'b0, 1'b0, 1'b1, 1'b0, 4'h5);

        // Asynchronous reset while in COMPARACAO
        #3;
        reset_n = 1'b0;
        #1;
        empilha("rstComp", 4'h0);
        confere();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        passo("posRst0", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        passo("posRst1", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

        // Waiting with no play
        passo("prep4", 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
        passo("espera4", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
`ifdef TIMEOUT_EN
        for (int i = 0; i < int'(c_TIMEOUT_CICLOS) - 1; i++) begin
            passo($sformatf("toEsp%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        end
        passo("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
        passo("timeoutHold", 1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
        passo("prep5", 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
`else
        for (int i = 0; i < 100; i++) begin
            passo($sformatf("semTo%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVetores, nErros);
        $finish;
    end

endmodule

`default_nettype wire
